cflow_mr: RTL and testbench
===========================

CFLOW_MR -- requirements
Module: cflow_mr

Interface
REQ-001 Param NUM_ER, default 2, number of executable regions monitored (1..4).
REQ-002 Param LOG_SIZE, default 16'h0080, log capacity in 16-bit words (even, >=8).
REQ-003 Param LOG_BASE, default 16'h0000, word address added to log pointer on log_addr.
REQ-004 clk  in  1  system clock.
REQ-005 puc  in  1  reset; asynchronous, active-high.
REQ-006 pc  in  16  current program counter.
REQ-007 pc_nxt  in  16  next program counter.
REQ-008 branch_detect  in  1  one-cycle pulse: control-flow transfer from pc to pc_nxt.
REQ-009 er_min  in  16*NUM_ER  region i lower bound in bits [16i+15:16i].
REQ-010 er_max  in  16*NUM_ER  region i upper bound, same packing.
REQ-011 flush_ack  in  1  TCB has consumed the log; pointer may restart.
REQ-012 hw_wen  out  1  log write strobe.
REQ-013 log_addr  out  16  log word address (LOG_BASE + ptr).
REQ-014 log_data  out  16  log word written.
REQ-015 cflow_log_ptr  out  16  words currently used.
REQ-016 flush  out  1  log full, TCB must drain; level until flush_ack.
REQ-017 er_done  out  1  one-cycle pulse on exit of active region.
REQ-018 er_id  out  2  index of active region.
REQ-019 overflow  out  1  sticky: a branch record was dropped.

Function
REQ-020 FSM states IDLE, ACTIVE, FLUSH, DONE; reset state IDLE.
REQ-021 IDLE->ACTIVE when pc == er_min[i]; lowest matching i latched into er_id.
REQ-022 ACTIVE->DONE when pc == er_max[er_id]; DONE pulses er_done one cycle then ->IDLE; queued records still drain.
REQ-023 Logging only in ACTIVE; branch_detect in IDLE/DONE ignored.
REQ-024 Record = two words: src=pc, then dest=pc_nxt; written on consecutive cycles starting the cycle after branch_detect; ptr +1 per word.
REQ-025 One-entry record buffer: branch_detect during an in-progress write is buffered; if buffer already full, record dropped, overflow set.
REQ-026 ACTIVE->FLUSH when ptr+2 > LOG_SIZE-2 after a write (room for one more record plus counter kept); flush held high in FLUSH.
REQ-027 In FLUSH: no writes; branches set overflow; flush_ack clears ptr to 0 and returns to ACTIVE (or IDLE if region exited meanwhile).
REQ-028 flush_ack outside FLUSH ignored.
REQ-029 hw_wen, log_addr, log_data registered; log_addr wraps modulo 2^16.
REQ-030 er_done and flush_ack same cycle: DONE taken; flush remains until ack received in FLUSH.

Reset
REQ-031 puc asynchronously forces: state IDLE, ptr 0, buffer empty, loop counter 0, hw_wen 0, flush 0, er_done 0, er_id 0, overflow 0, log_addr LOG_BASE, log_data 0.
REQ-032 puc mid-record aborts partial record; no further word written.

Configuration
REQ-033 Macro CFLOW_LOOP_CMP_EN defined: record equal to last logged (src,dest) not written; 16-bit loop counter increments (saturates FFFF).
REQ-034 With it: on next differing record, region exit, or flush entry with counter>0, counter entry 16'h0000 then count written before anything else; counter cleared.
REQ-035 Without it: every record written; counter logic absent.

Structure
REQ-036 Shared package cflow_pkg: FSM state encoding, counter marker 16'h0000, NUM_ER max constant.
REQ-037 One sub-module cflow_er_match: combinational entry/exit compare per region, outputs match vector and exit flag.

Verification
REQ-038 er_min0=E000,er_max0=E0FE; pc=E000 then branch E010->E040 -> words E010,E040 at ptr 0,1; er_id=0.
REQ-039 LOG_SIZE=8, four distinct branches -> flush=1 after ptr=6, 4th dropped, overflow=1; flush_ack -> ptr=0, ACTIVE.
REQ-040 CFLOW_LOOP_CMP_EN, branch E020->E010 x5 then E030->E050 -> E020,E010,0000,0004,E030,E050.
REQ-041 pc reaches er_max0=E0FE -> er_done single pulse, state IDLE, later branches not logged.
REQ-042 Branch pulses 1 cycle apart, then third during buffered write -> two records logged, overflow=1.
REQ-043 puc asserted between src and dest words -> hw_wen low same cycle, ptr=0.

Source files
------------

// File: rtl/cflow_pkg.sv
// Shared definitions for the control-flow monitor: FSM state encoding, the
// log record layout used by the write engine, and the loop-counter marker.
package cflow_pkg;

  localparam int          MAX_ER     = 4;
  localparam logic [15:0] CNT_MARKER = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } cflow_state_e;

  // has_cnt prefixes {CNT_MARKER, cnt}; has_br appends {src, dst}.
  typedef struct packed {
    logic        has_cnt;
    logic [15:0] cnt;
    logic        has_br;
    logic [15:0] src;
    logic [15:0] dst;
  } cflow_rec_t;

endpackage

// File: rtl/cflow_er_match.sv
// Combinational region compare: per-region entry hits on er_min, lowest-index
// encoding of the entry vector, and exit hit on the active region's er_max.
module cflow_er_match
  import cflow_pkg::*;
#(
  parameter int NUM_ER = 2
) (
  input  logic [15:0]          pc_i,
  input  logic [16*NUM_ER-1:0] er_min_i,
  input  logic [16*NUM_ER-1:0] er_max_i,
  input  logic [1:0]           er_id_i,
  output logic [MAX_ER-1:0]    entry_vec_o,
  output logic [1:0]           entry_id_o,
  output logic                 exit_hit_o
);

  logic [MAX_ER-1:0] exit_vec;

  for (genvar gi = 0; gi < MAX_ER; gi++) begin : g_cmp
    if (gi < NUM_ER) begin : g_used
      assign entry_vec_o[gi] = (pc_i == er_min_i[16*gi +: 16]);
      assign exit_vec[gi]    = (pc_i == er_max_i[16*gi +: 16]);
    end else begin : g_unused
      assign entry_vec_o[gi] = 1'b0;
      assign exit_vec[gi]    = 1'b0;
    end
  end

  // Scan downwards so the lowest matching region wins.
  always_comb begin
    entry_id_o = 2'd0;
    for (int i = MAX_ER - 1; i >= 0; i--) begin
      if (entry_vec_o[i]) entry_id_o = 2'(i);
    end
  end

  assign exit_hit_o = exit_vec[er_id_i];

endmodule

// File: rtl/cflow_mr.sv
// Control-flow monitor: logs (src,dest) branch pairs taken inside an executable
// region into a word log. Optional loop compression under CFLOW_LOOP_CMP_EN.
module cflow_mr
  import cflow_pkg::*;
#(
  parameter int          NUM_ER   = 2,
  parameter logic [15:0] LOG_SIZE = 16'h0080,
  parameter logic [15:0] LOG_BASE = 16'h0000
) (
  input  logic                 clk,
  input  logic                 puc,
  input  logic [15:0]          pc,
  input  logic [15:0]          pc_nxt,
  input  logic                 branch_detect,
  input  logic [16*NUM_ER-1:0] er_min,
  input  logic [16*NUM_ER-1:0] er_max,
  input  logic                 flush_ack,
  output logic                 hw_wen,
  output logic [15:0]          log_addr,
  output logic [15:0]          log_data,
  output logic [15:0]          cflow_log_ptr,
  output logic                 flush,
  output logic                 er_done,
  output logic [1:0]           er_id,
  output logic                 overflow
);

  cflow_state_e     state_q, state_d;
  logic [1:0]       er_id_q, er_id_d;
  logic             exited_q, exited_d;
  logic [15:0]      ptr_q, ptr_d;
  logic             overflow_q, overflow_d;
  logic             hw_wen_q, hw_wen_d;
  logic [15:0]      log_addr_q, log_addr_d;
  logic [15:0]      log_data_q, log_data_d;
  logic [1:0]       pend_cnt_q, pend_cnt_d;
  logic [2:0][15:0] pend_q, pend_d;
  logic             buf_vld_q, buf_vld_d;
  cflow_rec_t       buf_q, buf_d;

  logic              in_vld;
  cflow_rec_t        in_rec;
  cflow_rec_t        take;
  logic              take_vld, in_direct, emit_vld;
  logic [15:0]       emit_word;
  logic              logging, emit_ok, rec_done, go_flush;
  logic              entry_hit, exit_hit;
  logic [1:0]        entry_id;
  logic [MAX_ER-1:0] entry_vec;

  cflow_er_match #(.NUM_ER(NUM_ER)) u_match (
    .pc_i        (pc),
    .er_min_i    (er_min),
    .er_max_i    (er_max),
    .er_id_i     (er_id_q),
    .entry_vec_o (entry_vec),
    .entry_id_o  (entry_id),
    .exit_hit_o  (exit_hit)
  );

  assign entry_hit = |entry_vec;
  assign logging   = (state_q == ST_ACTIVE);
  assign emit_ok   = (state_q != ST_FLUSH);
  assign rec_done  = emit_ok && (pend_cnt_q == 2'd1);
  // Fill check once a record completes: keep room for one record plus counter.
  assign go_flush  = logging && !exit_hit && rec_done &&
                     (({1'b0, ptr_q} + 17'd3) > ({1'b0, LOG_SIZE} - 17'd2));

`ifdef CFLOW_LOOP_CMP_EN
  logic [15:0] loop_cnt_q, loop_cnt_d, cnt_inc, cnt_now;
  logic        last_vld_q, last_vld_d;
  logic [15:0] last_src_q, last_src_d, last_dst_q, last_dst_d;
  logic        rec_eq;

  always_comb begin
    cnt_inc    = (loop_cnt_q == 16'hFFFF) ? loop_cnt_q : loop_cnt_q + 16'd1;
    rec_eq     = logging && branch_detect && last_vld_q &&
                 (pc == last_src_q) && (pc_nxt == last_dst_q);
    cnt_now    = rec_eq ? cnt_inc : loop_cnt_q;
    loop_cnt_d = cnt_now;
    last_vld_d = last_vld_q;
    last_src_d = last_src_q;
    last_dst_d = last_dst_q;
    in_vld     = 1'b0;
    in_rec     = '0;
    if (logging && branch_detect && !rec_eq) begin
      in_vld         = 1'b1;
      in_rec.has_cnt = (loop_cnt_q != 16'h0000);
      in_rec.cnt     = loop_cnt_q;
      in_rec.has_br  = 1'b1;
      in_rec.src     = pc;
      in_rec.dst     = pc_nxt;
      loop_cnt_d     = 16'h0000;
      last_vld_d     = 1'b1;
      last_src_d     = pc;
      last_dst_d     = pc_nxt;
    end else if (logging && (exit_hit || go_flush) && (cnt_now != 16'h0000)) begin
      in_vld         = 1'b1;
      in_rec.has_cnt = 1'b1;
      in_rec.cnt     = cnt_now;
      loop_cnt_d     = 16'h0000;
    end
  end

  always_ff @(posedge clk or posedge puc) begin
    if (puc) begin
      loop_cnt_q <= 16'h0000;
      last_vld_q <= 1'b0;
      last_src_q <= 16'h0000;
      last_dst_q <= 16'h0000;
    end else begin
      loop_cnt_q <= loop_cnt_d;
      last_vld_q <= last_vld_d;
      last_src_q <= last_src_d;
      last_dst_q <= last_dst_d;
    end
  end
`else
  always_comb begin
    in_vld        = logging && branch_detect;
    in_rec        = '0;
    in_rec.has_br = 1'b1;
    in_rec.src    = pc;
    in_rec.dst    = pc_nxt;
  end
`endif

  always_comb begin
    state_d    = state_q;
    er_id_d    = er_id_q;
    exited_d   = exited_q;
    ptr_d      = ptr_q;
    overflow_d = overflow_q;
    hw_wen_d   = 1'b0;
    log_addr_d = log_addr_q;
    log_data_d = log_data_q;
    pend_cnt_d = pend_cnt_q;
    pend_d     = pend_q;
    buf_vld_d  = buf_vld_q;
    buf_d      = buf_q;
    emit_vld   = 1'b0;
    emit_word  = 16'h0000;
    take_vld   = 1'b0;
    take       = in_rec;
    in_direct  = 1'b0;

    // Word engine: finish the current record, then the buffer, then new input.
    if (emit_ok && (pend_cnt_q != 2'd0)) begin
      emit_vld   = 1'b1;
      emit_word  = pend_q[0];
      pend_d     = {16'h0000, pend_q[2:1]};
      pend_cnt_d = pend_cnt_q - 2'd1;
    end else if (emit_ok && buf_vld_q) begin
      take_vld  = 1'b1;
      take      = buf_q;
      buf_vld_d = 1'b0;
    end else if (emit_ok && in_vld) begin
      take_vld  = 1'b1;
      in_direct = 1'b1;
    end

    if (take_vld) begin
      emit_vld = 1'b1;
      if (take.has_cnt) begin
        emit_word  = CNT_MARKER;
        pend_d     = {take.dst, take.src, take.cnt};
        pend_cnt_d = take.has_br ? 2'd3 : 2'd1;
      end else begin
        emit_word  = take.src;
        pend_d     = {32'h0000_0000, take.dst};
        pend_cnt_d = 2'd1;
      end
    end

    if (emit_vld) begin
      hw_wen_d   = 1'b1;
      log_data_d = emit_word;
      log_addr_d = LOG_BASE + ptr_q;
      ptr_d      = ptr_q + 16'd1;
    end

    // A full buffer at arrival time drops the record even if it drains now.
    if (in_vld && !in_direct) begin
      if (buf_vld_q) begin
        overflow_d = 1'b1;
      end else begin
        buf_vld_d = 1'b1;
        buf_d     = in_rec;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (entry_hit) begin
          state_d = ST_ACTIVE;
          er_id_d = entry_id;
        end
      end
      ST_ACTIVE: begin
        if (exit_hit)      state_d = ST_DONE;
        else if (go_flush) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (branch_detect) overflow_d = 1'b1;
        if (flush_ack) begin
          ptr_d    = 16'h0000;
          exited_d = 1'b0;
          state_d  = (exited_q || exit_hit) ? ST_IDLE : ST_ACTIVE;
        end else if (exit_hit) begin
          exited_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge puc) begin
    if (puc) begin
      state_q    <= ST_IDLE;
      er_id_q    <= 2'd0;
      exited_q   <= 1'b0;
      ptr_q      <= 16'h0000;
      overflow_q <= 1'b0;
      hw_wen_q   <= 1'b0;
      log_addr_q <= LOG_BASE;
      log_data_q <= 16'h0000;
      pend_cnt_q <= 2'd0;
      pend_q     <= '0;
      buf_vld_q  <= 1'b0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      er_id_q    <= er_id_d;
      exited_q   <= exited_d;
      ptr_q      <= ptr_d;
      overflow_q <= overflow_d;
      hw_wen_q   <= hw_wen_d;
      log_addr_q <= log_addr_d;
      log_data_q <= log_data_d;
      pend_cnt_q <= pend_cnt_d;
      pend_q     <= pend_d;
      buf_vld_q  <= buf_vld_d;
      buf_q      <= buf_d;
    end
  end

  assign hw_wen        = hw_wen_q;
  assign log_addr      = log_addr_q;
  assign log_data      = log_data_q;
  assign cflow_log_ptr = ptr_q;
  assign flush         = (state_q == ST_FLUSH);
  assign er_done       = (state_q == ST_DONE);
  assign er_id         = er_id_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_cflow_mr.sv
// Directed bench for cflow_mr: log writes are captured on the falling edge and
// compared against hand-computed word lists per scenario.
module tb_cflow_mr;

  logic        clk = 1'b0;
  logic        puc;
  logic [15:0] pc, pc_nxt;
  logic        branch_detect, flush_ack;
  logic [31:0] er_min, er_max;
  logic        hw_wen, flush, er_done, overflow;
  logic [15:0] log_addr, log_data, cflow_log_ptr;
  logic [1:0]  er_id;

  int total = 0;
  int bad   = 0;
  logic [31:0] wq[$];

  cflow_mr #(.NUM_ER(2), .LOG_SIZE(16'd8), .LOG_BASE(16'h0100)) dut (
    .clk           (clk),
    .puc           (puc),
    .pc            (pc),
    .pc_nxt        (pc_nxt),
    .branch_detect (branch_detect),
    .er_min        (er_min),
    .er_max        (er_max),
    .flush_ack     (flush_ack),
    .hw_wen        (hw_wen),
    .log_addr      (log_addr),
    .log_data      (log_data),
    .cflow_log_ptr (cflow_log_ptr),
    .flush         (flush),
    .er_done       (er_done),
    .er_id         (er_id),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (hw_wen === 1'b1) begin
      wq.push_back({log_addr, log_data});
      $display("write addr=%h data=%h", log_addr, log_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    puc = 1'b1; branch_detect = 1'b0; flush_ack = 1'b0;
    pc = 16'h1000; pc_nxt = 16'h1002;
    er_min = {16'hF000, 16'hE000};
    er_max = {16'hF0FE, 16'hE0FE};
    tick(); tick();
    puc = 1'b0;
    tick();
    wq.delete();
  endtask

  task automatic enter(input logic [15:0] a);
    pc = a; tick(); pc = 16'h1000;
  endtask

  task automatic branch(input logic [15:0] s, input logic [15:0] d);
    pc = s; pc_nxt = d; branch_detect = 1'b1;
    tick();
    branch_detect = 1'b0; pc = 16'h1000; pc_nxt = 16'h1002;
  endtask

  task automatic test_reset();
    puc = 1'b1; branch_detect = 1'b0; flush_ack = 1'b0;
    pc = 16'h1000; pc_nxt = 16'h1002;
    er_min = {16'hF000, 16'hE000}; er_max = {16'hF0FE, 16'hE0FE};
    tick();
    total++; if (hw_wen !== 1'b0) begin bad++; $display("FAIL rst_hw_wen got=%b want=0", hw_wen); end
    total++; if (log_addr !== 16'h0100) begin bad++; $display("FAIL rst_log_addr got=%h want=0100", log_addr); end
    total++; if (log_data !== 16'h0000) begin bad++; $display("FAIL rst_log_data got=%h want=0000", log_data); end
    total++; if (cflow_log_ptr !== 16'h0000) begin bad++; $display("FAIL rst_ptr got=%h want=0000", cflow_log_ptr); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL rst_flush got=%b want=0", flush); end
    total++; if (er_done !== 1'b0) begin bad++; $display("FAIL rst_er_done got=%b want=0", er_done); end
    total++; if (er_id !== 2'd0) begin bad++; $display("FAIL rst_er_id got=%0d want=0", er_id); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b want=0", overflow); end
    puc = 1'b0;
    tick();
  endtask

  task automatic test_basic_record();
    do_reset();
    enter(16'hE000);
    branch(16'hE010, 16'hE040);
    tick(); tick();
    total++; if (wq.size() != 2) begin bad++; $display("FAIL basic_count got=%0d want=2", wq.size()); end
    total++; if (wq.size() > 0 && wq[0] !== 32'h0100_E010) begin bad++; $display("FAIL basic_src got=%h want=0100E010", wq[0]); end
    total++; if (wq.size() > 1 && wq[1] !== 32'h0101_E040) begin bad++; $display("FAIL basic_dst got=%h want=0101E040", wq[1]); end
    total++; if (cflow_log_ptr !== 16'd2) begin bad++; $display("FAIL basic_ptr got=%0d want=2", cflow_log_ptr); end
    total++; if (er_id !== 2'd0) begin bad++; $display("FAIL basic_er_id got=%0d want=0", er_id); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL basic_overflow got=%b want=0", overflow); end
  endtask

  // Continues from test_basic_record: region 0 active, ptr=2.
  task automatic test_exit();
    pc = 16'hE0FE;
    tick();
    total++; if (er_done !== 1'b1) begin bad++; $display("FAIL exit_pulse_hi got=%b want=1", er_done); end
    pc = 16'h1000;
    tick();
    total++; if (er_done !== 1'b0) begin bad++; $display("FAIL exit_pulse_lo got=%b want=0", er_done); end
    branch(16'hE011, 16'hE041);
    tick(); tick();
    total++; if (wq.size() != 2) begin bad++; $display("FAIL exit_nolog got=%0d want=2", wq.size()); end
    total++; if (cflow_log_ptr !== 16'd2) begin bad++; $display("FAIL exit_ptr got=%0d want=2", cflow_log_ptr); end
  endtask

  task automatic test_region_id();
    do_reset();
    enter(16'hF000);
    total++; if (er_id !== 2'd1) begin bad++; $display("FAIL region1_id got=%0d want=1", er_id); end
    do_reset();
    er_min = {16'hE000, 16'hE000};
    enter(16'hE000);
    total++; if (er_id !== 2'd0) begin bad++; $display("FAIL lowest_id got=%0d want=0", er_id); end
    er_min = {16'hF000, 16'hE000};
  endtask

  task automatic test_flush();
    logic [31:0] exp_w [6];
    exp_w = '{32'h0100_E101, 32'h0101_E201, 32'h0102_E102,
              32'h0103_E202, 32'h0104_E103, 32'h0105_E203};
    do_reset();
    enter(16'hE000);
    branch(16'hE101, 16'hE201); tick(); tick();
    flush_ack = 1'b1; tick(); flush_ack = 1'b0;
    total++; if (cflow_log_ptr !== 16'd2) begin bad++; $display("FAIL ack_ignored_ptr got=%0d want=2", cflow_log_ptr); end
    branch(16'hE102, 16'hE202); tick(); tick();
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL flush_early got=%b want=0", flush); end
    branch(16'hE103, 16'hE203); tick();
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL flush_set got=%b want=1", flush); end
    total++; if (cflow_log_ptr !== 16'd6) begin bad++; $display("FAIL flush_ptr got=%0d want=6", cflow_log_ptr); end
    tick();
    branch(16'hE104, 16'hE204); tick(); tick();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL flush_overflow got=%b want=1", overflow); end
    total++; if (wq.size() != 6) begin bad++; $display("FAIL flush_count got=%0d want=6", wq.size()); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (wq.size() > i && wq[i] !== exp_w[i]) begin
        bad++; $display("FAIL flush_word%0d got=%h want=%h", i, wq[i], exp_w[i]);
      end
    end
    flush_ack = 1'b1; tick(); flush_ack = 1'b0;
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL flush_clear got=%b want=0", flush); end
    total++; if (cflow_log_ptr !== 16'd0) begin bad++; $display("FAIL flush_ack_ptr got=%0d want=0", cflow_log_ptr); end
    branch(16'hE105, 16'hE205);
    total++; if (wq.size() != 7 || wq[6] !== 32'h0100_E105) begin
      bad++; $display("FAIL flush_resume size=%0d want=7 last=%h want=0100E105", wq.size(), wq[wq.size()-1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [4];
    exp_w = '{32'h0100_E301, 32'h0101_E401, 32'h0102_E302, 32'h0103_E402};
    do_reset();
    enter(16'hE000);
    branch_detect = 1'b1;
    pc = 16'hE301; pc_nxt = 16'hE401; tick();
    pc = 16'hE302; pc_nxt = 16'hE402; tick();
    pc = 16'hE303; pc_nxt = 16'hE403; tick();
    branch_detect = 1'b0; pc = 16'h1000;
    tick(); tick(); tick(); tick();
    total++; if (wq.size() != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", wq.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (wq.size() > i && wq[i] !== exp_w[i]) begin
        bad++; $display("FAIL b2b_word%0d got=%h want=%h", i, wq[i], exp_w[i]);
      end
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL b2b_overflow got=%b want=1", overflow); end
    total++; if (cflow_log_ptr !== 16'd4) begin bad++; $display("FAIL b2b_ptr got=%0d want=4", cflow_log_ptr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    enter(16'hE000);
    branch(16'hE010, 16'hE040);
    total++; if (hw_wen !== 1'b1) begin bad++; $display("FAIL mid_src_wen got=%b want=1", hw_wen); end
    puc = 1'b1;
    #1;
    total++; if (hw_wen !== 1'b0) begin bad++; $display("FAIL mid_async_wen got=%b want=0", hw_wen); end
    total++; if (cflow_log_ptr !== 16'd0) begin bad++; $display("FAIL mid_async_ptr got=%0d want=0", cflow_log_ptr); end
    tick();
    puc = 1'b0;
    tick(); tick(); tick();
    total++; if (wq.size() != 1) begin bad++; $display("FAIL mid_no_dest got=%0d want=1", wq.size()); end
  endtask

`ifdef CFLOW_LOOP_CMP_EN
  task automatic test_loop_cmp();
    logic [15:0] exp_d [6];
    exp_d = '{16'hE020, 16'hE010, 16'h0000, 16'h0004, 16'hE030, 16'hE050};
    do_reset();
    enter(16'hE000);
    for (int k = 0; k < 5; k++) begin
      branch(16'hE020, 16'hE010); tick(); tick();
    end
    branch(16'hE030, 16'hE050);
    tick(); tick(); tick(); tick(); tick();
    total++; if (wq.size() != 6) begin bad++; $display("FAIL loop_count got=%0d want=6", wq.size()); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (wq.size() > i && wq[i] !== {16'h0100 + 16'(i), exp_d[i]}) begin
        bad++; $display("FAIL loop_word%0d got=%h want=%h", i, wq[i], {16'h0100 + 16'(i), exp_d[i]});
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_record();
    test_exit();
    test_region_id();
    test_flush();
    test_back_to_back();
    test_reset_mid();
`ifdef CFLOW_LOOP_CMP_EN
    test_loop_cmp();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
